// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared constants and state type for the gated frequency counter
// Purpose: FSM state encoding, prime length and synchronizer depth used by freq_meter and edge_sync.
package freq_meter_pkg;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_GATE  = 1'b1
    } state_t;

    localparam int PRIME_CYCLES = 3;
    localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with delay flop and rising-edge pulse
// Purpose: bring an asynchronous level into the clock domain and flag its rising edges.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset, clears all flops
//   i_async - asynchronous input level
//   o_level - synchronized level
//   o_rise  - one-cycle pulse on a synchronized rising edge
module edge_sync
    import freq_meter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter with hold button and LED slice
// Purpose: count rising edges of sig_in over GATE_CYCLES clocks and publish the count.
// Optional feature macro: FREQ_METER_PERIOD_EN adds period_out/period_valid (edge-to-edge period).
// Ports:
//   clk_200mhz   - sole clock
//   rst          - synchronous active-high reset
//   sig_in       - measured signal (asynchronous)
//   button       - hold request (asynchronous, active-high)
//   result       - edge count of last completed window (saturating)
//   result_valid - one-cycle strobe when result updates
//   overflow     - last published window saturated
//   led          - result[LED_SHIFT+7:LED_SHIFT]
//   period_out   - clocks between successive edges (FREQ_METER_PERIOD_EN only)
//   period_valid - one-cycle strobe when period_out updates (FREQ_METER_PERIOD_EN only)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 200000000,
    parameter int CNT_W       = 32,
    parameter int LED_SHIFT   = 0
) (
    input  logic             clk_200mhz,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             button,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic [7:0]       led
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid
`endif
);

    localparam int               GW         = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [1:0]       PRIME_LAST = 2'(PRIME_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_prime_cnt;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;

    logic             w_sig_level_unused;
    logic             w_sig_rise;
    logic             w_hold;
    logic             w_btn_rise_unused;
    logic             w_gate_end;
    logic             w_edge;
    logic             w_at_max;
    logic [CNT_W-1:0] w_final;
    logic             w_final_sat;

    edge_sync u_sig_sync (
        .i_clk   (clk_200mhz),
        .i_rst   (rst),
        .i_async (sig_in),
        .o_level (w_sig_level_unused),
        .o_rise  (w_sig_rise)
    );

    edge_sync u_btn_sync (
        .i_clk   (clk_200mhz),
        .i_rst   (rst),
        .i_async (button),
        .o_level (w_hold),
        .o_rise  (w_btn_rise_unused)
    );

    always_ff @(posedge clk_200mhz) begin
        if (rst) r_state <= ST_PRIME;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gate_end  = 1'b0;
        case (r_state)
            ST_PRIME: if (r_prime_cnt == PRIME_LAST) w_state_nxt = ST_GATE;
            ST_GATE:  w_gate_end = (r_gate_cnt == GATE_LAST);
            default:  w_state_nxt = ST_PRIME;
        endcase
    end

    // Edges seen while the synchronizers are still flushing are discarded.
    assign w_edge   = w_sig_rise & (r_state == ST_GATE);
    assign w_at_max = &r_edge_cnt;

    // The closing cycle's own edge belongs to the window being published.
    assign w_final     = (w_edge && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_final_sat = r_sat | (w_edge & w_at_max);

    always_ff @(posedge clk_200mhz) begin
        if (rst) begin
            r_prime_cnt  <= '0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            led          <= '0;
        end else begin
            result_valid <= 1'b0;
            if (r_state == ST_PRIME) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
                r_gate_cnt  <= '0;
                r_edge_cnt  <= '0;
                r_sat       <= 1'b0;
            end else if (w_gate_end) begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
                if (!w_hold) begin
                    result       <= w_final;
                    overflow     <= w_final_sat;
                    result_valid <= 1'b1;
                    led          <= 8'(w_final >> LED_SHIFT);
                end
            end else begin
                r_gate_cnt <= r_gate_cnt + GW'(1);
                if (w_edge) begin
                    if (w_at_max) r_sat      <= 1'b1;
                    else          r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_per_cnt;
    logic             r_per_armed;

    // The counter restarts at 1 on an edge so its value at the next edge is the cycle distance.
    always_ff @(posedge clk_200mhz) begin
        if (rst) begin
            r_per_cnt    <= '0;
            r_per_armed  <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_edge) begin
                r_per_cnt   <= CNT_W'(1);
                r_per_armed <= 1'b1;
                if (r_per_armed && !w_hold) begin
                    period_out   <= r_per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (!(&r_per_cnt)) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized scoreboard bench for freq_meter (32-bit and 4-bit counters)
module tb_freq_meter;

    localparam int G     = 100;
    localparam int MAX_B = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic button = 1'b0;

    logic [31:0] res_a;
    logic        val_a;
    logic        ovf_a;
    logic [7:0]  led_a;
    logic [3:0]  res_b;
    logic        val_b;
    logic        ovf_b;
    logic [7:0]  led_b;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] per_a;
    logic        pv_a;
    logic [3:0]  per_b;
    logic        pv_b;
`endif

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .LED_SHIFT(0)) dut_a (
        .clk_200mhz   (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .button       (button),
        .result       (res_a),
        .result_valid (val_a),
        .overflow     (ovf_a),
        .led          (led_a)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out   (per_a),
        .period_valid (pv_a)
`endif
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .LED_SHIFT(0)) dut_b (
        .clk_200mhz   (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .button       (button),
        .result       (res_b),
        .result_valid (val_b),
        .overflow     (ovf_b),
        .led          (led_b)
`ifdef FREQ_METER_PERIOD_EN
        ,
        .period_out   (per_b),
        .period_valid (pv_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_pa[$];
    exp_t q_pb[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat_to(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: cycle p counts clocks since reset release. A rise of sig_in seen
    // at clock p is acted on at clock p+2; windows of G clocks start at clock 3.
    int   p = 0;
    int   m_t;
    int   m_cnt = 0;
    int   m_last = 0;
    bit   m_armed = 0;
    bit   m_prev = 0;
    bit   m_rst = 1;
    exp_t m_e;

    always @(posedge clk) begin
        m_rst = rst;
        if (rst) begin
            p = 0;
            m_cnt = 0;
            m_prev = 0;
            m_armed = 0;
            q_a.delete();
            q_b.delete();
            q_pa.delete();
            q_pb.delete();
        end else begin
            m_t = p + 2;
            if (m_t >= 3) begin
                if (sig_in && !m_prev) begin
                    m_cnt++;
                    if (m_armed && !button) begin
                        m_e.cnt = m_t - m_last;
                        m_e.cyc = m_t + 1;
                        q_pa.push_back(m_e);
                        q_pb.push_back(m_e);
                    end
                    m_armed = 1;
                    m_last = m_t;
                end
                if ((m_t - 3) % G == G - 1) begin
                    if (!button) begin
                        m_e.cnt = m_cnt;
                        m_e.cyc = m_t + 1;
                        q_a.push_back(m_e);
                        q_b.push_back(m_e);
                    end
                    m_cnt = 0;
                end
            end
            m_prev = sig_in;
            p++;
        end
    end

    exp_t e_a, e_b;
    int   last_a = 0;
    int   last_b = 0;

    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_result_a", res_a, 0);
            chk("rst_valid_a", val_a, 0);
            chk("rst_overflow_a", ovf_a, 0);
            chk("rst_led_a", led_a, 0);
            last_a = 0;
        end else begin
            while (q_a.size() > 0 && q_a[0].cyc < p) begin
                chk("missing_valid_a_cycle", p, q_a[0].cyc);
                void'(q_a.pop_front());
            end
            if (val_a) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_valid_a", 1, 0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("valid_cycle_a", p, e_a.cyc);
                    chk("result_a", res_a, e_a.cnt);
                    chk("overflow_a", ovf_a, 0);
                    chk("led_a", led_a, e_a.cnt & 255);
                    last_a = e_a.cnt;
                end
            end else begin
                chk("hold_result_a", res_a, last_a);
            end
        end
    end

    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_result_b", res_b, 0);
            chk("rst_valid_b", val_b, 0);
            chk("rst_overflow_b", ovf_b, 0);
            chk("rst_led_b", led_b, 0);
            last_b = 0;
        end else begin
            while (q_b.size() > 0 && q_b[0].cyc < p) begin
                chk("missing_valid_b_cycle", p, q_b[0].cyc);
                void'(q_b.pop_front());
            end
            if (val_b) begin
                if (q_b.size() == 0) begin
                    chk("unexpected_valid_b", 1, 0);
                end else begin
                    e_b = q_b.pop_front();
                    chk("valid_cycle_b", p, e_b.cyc);
                    chk("result_b", res_b, sat_to(e_b.cnt, MAX_B));
                    chk("overflow_b", ovf_b, (e_b.cnt > MAX_B) ? 1 : 0);
                    chk("led_b", led_b, sat_to(e_b.cnt, MAX_B));
                    last_b = sat_to(e_b.cnt, MAX_B);
                end
            end else begin
                chk("hold_result_b", res_b, last_b);
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    exp_t e_pa, e_pb;

    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_period_valid_a", pv_a, 0);
            chk("rst_period_valid_b", pv_b, 0);
        end else begin
            while (q_pa.size() > 0 && q_pa[0].cyc < p) begin
                chk("missing_period_a_cycle", p, q_pa[0].cyc);
                void'(q_pa.pop_front());
            end
            while (q_pb.size() > 0 && q_pb[0].cyc < p) begin
                chk("missing_period_b_cycle", p, q_pb[0].cyc);
                void'(q_pb.pop_front());
            end
            if (pv_a) begin
                if (q_pa.size() == 0) begin
                    chk("unexpected_period_a", 1, 0);
                end else begin
                    e_pa = q_pa.pop_front();
                    chk("period_cycle_a", p, e_pa.cyc);
                    chk("period_a", per_a, e_pa.cnt);
                end
            end
            if (pv_b) begin
                if (q_pb.size() == 0) begin
                    chk("unexpected_period_b", 1, 0);
                end else begin
                    e_pb = q_pb.pop_front();
                    chk("period_cycle_b", p, e_pb.cyc);
                    chk("period_b", per_b, sat_to(e_pb.cnt, MAX_B));
                end
            end
        end
    end
`endif

    int ph = 0;

    // half == 0 holds sig_in at lvl; otherwise sig_in toggles every half clocks.
    task automatic run(input int half, input int ncyc, input bit lvl);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (half == 0) begin
                sig_in = lvl;
                ph = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    sig_in = ~sig_in;
                    ph = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sig_in = 1'b1;
        button = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, 3 * G, 1'b1);
        run(5, 3 * G + $urandom_range(0, 99), 1'b0);
        run(2, 2 * G, 1'b0);
        run(5, G, 1'b0);
        button = 1'b1;
        run(5, 3 * G, 1'b0);
        run(10, G, 1'b0);
        button = 1'b0;
        run(10, 2 * G, 1'b0);
        for (int s = 0; s < 6; s++) begin
            button = ($urandom_range(0, 3) == 0);
            run($urandom_range(1, 15), $urandom_range(50, 250), 1'b0);
        end
        button = 1'b0;
        run(5, $urandom_range(120, 260), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(5, 3 * G, 1'b0);
        run(0, 20, 1'b0);
        @(negedge clk);
        chk("drained_a", q_a.size(), 0);
        chk("drained_b", q_b.size(), 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("drained_period_a", q_pa.size(), 0);
        chk("drained_period_b", q_pb.size(), 0);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
